// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, lane steering for stores,
// sign/zero extension for loads, and a bounded wait for memory completion.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        req_illegal;
    logic [1:0]  lane;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [3:0]  be_lanes;
    logic [31:0] wdata_lanes;

    // Legality is judged on the live request so an illegal access skips ISSUE.
    always_comb begin
        req_illegal = 1'b0;
        case (req_funct3)
            3'b000:  req_illegal = 1'b0;
            3'b001:  req_illegal = req_addr[0];
            3'b010:  req_illegal = (req_addr[1:0] != 2'b00);
            3'b100:  req_illegal = req_store;
            3'b101:  req_illegal = req_store | req_addr[0];
            default: req_illegal = 1'b1;
        endcase
    end

    always_comb begin
        lane    = addr_q[1:0];
        rd_byte = mem_rdata[{lane, 3'b000} +: 8];
        rd_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = mem_rdata;
            3'b100:  load_data = {24'h000000, rd_byte};
            3'b101:  load_data = {16'h0000, rd_half};
            default: load_data = 32'h0000_0000;
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                be_lanes    = 4'b0001 << lane;
                wdata_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_lanes    = 4'b0011 << {addr_q[1], 1'b0};
                wdata_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                be_lanes    = 4'b1111;
                wdata_lanes = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            store_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_illegal) begin
                        state_d     = StResp;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0000_0000;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // Completion wins over a timeout landing in the same cycle.
                if (mem_rvalid) begin
                    state_d     = StResp;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = store_q ? 32'h0000_0000 : load_data;
                end else if (cnt_q == CntW'(TIMEOUT)) begin
                    state_d     = StResp;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are forced low while rst is held, even before the reset edge.
    always_comb begin
        req_ready = !rst && (state_q == StIdle);
        mem_req   = !rst && (state_q == StIssue);
        mem_we    = mem_req & store_q;
        mem_be    = mem_req ? be_lanes : 4'b0000;
        mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0000_0000;
        mem_wdata = mem_req ? wdata_lanes : 32'h0000_0000;
        rsp_valid = !rst && (state_q == StResp);
        rsp_rdata = rst ? 32'h0000_0000 : rsp_rdata_q;
        rsp_err   = !rst && rsp_err_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of accesses plus
// hand-written reset-abandon sequences.
module tb_load_store_unit;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_store (req_store),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rv_k;      // WAIT cycle index carrying rvalid, -1 = never
        logic        stray;     // extra rvalid with junk data during ISSUE
        logic        exp_req;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 50 && req_ready !== 1'b1; i++) cycle();
        check32({name, "_ready"}, {31'b0, req_ready}, 32'h1);
    endtask

    task automatic accept(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        cycle();
        // Garbage after accept: the unit must work from its latched copy.
        req_valid  = 1'b0;
        req_store  = ~st;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h5A5A_5A5A;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        int req_cnt;
        int lat;
        tag = $sformatf("v%0d", idx);
        wait_ready(tag);
        accept(v.store, v.f3, v.addr, v.wdata);
        req_cnt = 0;
        lat = -1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
            if (v.stray && c == 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hFFFF_FFFF;
            end
            if (v.rv_k >= 0 && c == 2 + v.rv_k) begin
                mem_rvalid = 1'b1;
                mem_rdata  = v.rdata;
            end
            #1;
            if (mem_req === 1'b1) begin
                req_cnt++;
                if (v.exp_req) begin
                    check32({tag, "_we"}, {31'b0, mem_we}, {31'b0, v.exp_we});
                    check32({tag, "_be"}, {28'b0, mem_be}, {28'b0, v.exp_be});
                    check32({tag, "_addr"}, mem_addr, v.exp_addr);
                    check32({tag, "_wdata"}, mem_wdata, v.exp_wdata);
                end
            end
            if (rsp_valid === 1'b1) lat = c;
            if (lat < 0) cycle();
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check_int({tag, "_memreq_count"}, req_cnt, v.exp_req ? 1 : 0);
        check_int({tag, "_latency"}, lat, v.exp_lat);
        if (lat >= 0) begin
            check32({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
            check32({tag, "_err"}, {31'b0, rsp_err}, {31'b0, v.exp_err});
            cycle();
            check32({tag, "_rsp_pulse"}, {31'b0, rsp_valid}, 32'h0);
            check32({tag, "_rdata_hold"}, rsp_rdata, v.exp_rdata);
            check32({tag, "_err_hold"}, {31'b0, rsp_err}, {31'b0, v.exp_err});
            check32({tag, "_idle_ready"}, {31'b0, req_ready}, 32'h1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        // store f3 addr wdata rdata rv_k stray | req we be addr wdata lat rdata err
        vecs.push_back('{1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b0,
                         1'b1, 1'b0, 4'b1000, 32'h100, 32'h0, 3, 32'hFFFF_FF80, 1'b0});
        vecs.push_back('{1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_7F00, 0, 1'b0,
                         1'b1, 1'b0, 4'b1100, 32'h100, 32'h0, 3, 32'h0000_8001, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7F00, 0, 1'b0,
                         1'b1, 1'b0, 4'b1100, 32'h100, 32'h0, 3, 32'hFFFF_8001, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 32'h201, 32'hDEAD_BEA5, 32'h1234_5678, 0, 1'b0,
                         1'b1, 1'b1, 4'b0010, 32'h200, 32'hA5A5_A5A5, 3, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 3'b001, 32'h202, 32'hDEAD_BEA5, 32'h1234_5678, 0, 1'b0,
                         1'b1, 1'b1, 4'b1100, 32'h200, 32'hBEA5_BEA5, 3, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 3'b010, 32'h300, 32'h0123_4567, 32'h0, 0, 1'b0,
                         1'b1, 1'b1, 4'b1111, 32'h300, 32'h0123_4567, 3, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFE_F00D, 2, 1'b1,
                         1'b1, 1'b0, 4'b1111, 32'h104, 32'h0, 5, 32'hCAFE_F00D, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 32'h001, 32'h0, 32'h0000_A500, 0, 1'b0,
                         1'b1, 1'b0, 4'b0010, 32'h000, 32'h0, 3, 32'h0000_00A5, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h000, 32'h0, 32'h0000_007F, 0, 1'b0,
                         1'b1, 1'b0, 4'b0001, 32'h000, 32'h0, 3, 32'h0000_007F, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h000, 32'h0, 32'h0000_8000, 0, 1'b0,
                         1'b1, 1'b0, 4'b0011, 32'h000, 32'h0, 3, 32'hFFFF_8000, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h002, 32'h0, 32'h00FF_0000, 0, 1'b0,
                         1'b1, 1'b0, 4'b0100, 32'h000, 32'h0, 3, 32'hFFFF_FFFF, 1'b0});
        // Illegal accesses: answered one cycle after accept, no memory strobe.
        vecs.push_back('{1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b0,
                         1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 3'b001, 32'h003, 32'hDEAD_BEA5, 32'h0, 0, 1'b0,
                         1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 0, 1'b0,
                         1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 3'b100, 32'h000, 32'h0, 32'h0, 0, 1'b0,
                         1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 3'b001, 32'h105, 32'h0, 32'h0, 0, 1'b0,
                         1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 3'b110, 32'h000, 32'h0, 32'h0, 0, 1'b0,
                         1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 3'b111, 32'h000, 32'h0, 32'h0, 0, 1'b0,
                         1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1, 32'h0, 1'b1});
        // Timeout: WAIT entered at cycle 2, RESP TIMEOUT+1 cycles later.
        vecs.push_back('{1'b0, 3'b010, 32'h400, 32'h0, 32'h5555_AAAA, -1, 1'b0,
                         1'b1, 1'b0, 4'b1111, 32'h400, 32'h0, 3 + TIMEOUT, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 3'b010, 32'h400, 32'h0, 32'h5555_AAAA, TIMEOUT, 1'b0,
                         1'b1, 1'b0, 4'b1111, 32'h400, 32'h0, 3 + TIMEOUT, 32'h5555_AAAA,
                         1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h400, 32'h0, 32'h0F0F_0F0F, TIMEOUT - 1, 1'b0,
                         1'b1, 1'b0, 4'b1111, 32'h400, 32'h0, 2 + TIMEOUT, 32'h0F0F_0F0F,
                         1'b0});

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_rdata  = 32'h0;
        mem_rvalid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_ready", {31'b0, req_ready}, 32'h0);
        check32("rst_memreq", {31'b0, mem_req}, 32'h0);
        check32("rst_outs", {mem_we, mem_be, rsp_valid, rsp_err}, 32'h0);
        check32("rst_addr", mem_addr, 32'h0);
        check32("rst_wdata", mem_wdata, 32'h0);
        check32("rst_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        cycle();
        check32("post_rst_ready", {31'b0, req_ready}, 32'h1);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Reset during WAIT abandons the access; a late rvalid is ignored.
        wait_ready("rw");
        accept(1'b0, 3'b010, 32'h500, 32'h0);
        check32("rw_issue", {31'b0, mem_req}, 32'h1);
        cycle();
        rst = 1'b1;
        #1;
        check32("rw_rst_memreq", {31'b0, mem_req}, 32'h0);
        check32("rw_rst_ready", {31'b0, req_ready}, 32'h0);
        check32("rw_rst_rdata", rsp_rdata, 32'h0);
        cycle();
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        #1;
        check32("rw_ready_after", {31'b0, req_ready}, 32'h1);
        check32("rw_rdata_cleared", rsp_rdata, 32'h0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (rsp_valid !== 1'b0 || mem_req !== 1'b0) bad++;
        end
        mem_rvalid = 1'b0;
        check_int("rw_no_rsp", bad, 0);

        // Reset during ISSUE suppresses the strobe immediately.
        wait_ready("ri");
        accept(1'b1, 3'b010, 32'h600, 32'h1234_5678);
        rst = 1'b1;
        #1;
        check32("ri_memreq", {31'b0, mem_req}, 32'h0);
        check32("ri_we", {31'b0, mem_we}, 32'h0);
        cycle();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) mem_rvalid = 1'b1;
            cycle();
            if (rsp_valid !== 1'b0 || mem_req !== 1'b0) bad++;
        end
        mem_rvalid = 1'b0;
        check_int("ri_no_rsp", bad, 0);

        for (int i = 11; i < vecs.size(); i++) run_vec(i, vecs[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
